// File: rtl/spi_slv_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : spi_slv_pkg                                               |
// | Purpose  : Shared types and constants for the SPI slave register     |
// |            interface (state encoding, frame field positions, widths).|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package spi_slv_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int CMD_RD_BIT = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_slv_sync.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : spi_slv_sync                                              |
// | Purpose  : Resynchronises sck/ssn/mosi into clk and derives single-  |
// |            cycle edge pulses for sck and ssn.                        |
// | Ports    : clk, rst_n          clock, async active-low reset         |
// |            sck_i/ssn_i/mosi_i  raw SPI pins                          |
// |            ssn_o, mosi_o       synchronised levels                   |
// |            sck_rise_o/fall_o   one-clk pulses on synced sck edges    |
// |            ssn_fall_o/rise_o   one-clk pulses on synced ssn edges    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module spi_slv_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck_i,
  input  logic ssn_i,
  input  logic mosi_i,
  output logic ssn_o,
  output logic mosi_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic ssn_fall_o,
  output logic ssn_rise_o
);

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] ssn_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_prev_q;
  logic                   ssn_prev_q;

  // All three pins go through identical chains so mosi stays aligned
  // with the sck edge that samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      ssn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ssn_prev_q  <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], ssn_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      ssn_prev_q  <= ssn_sync_q[SYNC_STAGES-1];
    end
  end

  assign ssn_o      = ssn_sync_q[SYNC_STAGES-1];
  assign mosi_o     = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise_o =  sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign sck_fall_o = ~sck_sync_q[SYNC_STAGES-1] &  sck_prev_q;
  assign ssn_fall_o = ~ssn_sync_q[SYNC_STAGES-1] &  ssn_prev_q;
  assign ssn_rise_o =  ssn_sync_q[SYNC_STAGES-1] & ~ssn_prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_regif.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : spi_slave_regif                                           |
// | Purpose  : Oversampled SPI target decoding {rw,addr[6:0]} + data     |
// |            frames into a register-access bus; returns read data on   |
// |            miso. No logic runs on sck.                               |
// | Ports    : clk, rst_n            clock, async active-low reset       |
// |            cpol, cpha            SPI mode (static while ssn=1)       |
// |            sck, ssn, mosi, miso  SPI pins; miso_oe while selected    |
// |            reg_addr/wdata/we/re  register bus, one-clk strobes       |
// |            reg_rdata             read data, valid 1 clk after reg_re |
// | Config   : SPI_SLV_AUTOINC_EN - address increments after each data  |
// |            byte (wraps 7'h7F->7'h00); undefined keeps it fixed.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module spi_slave_regif
  import spi_slv_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_TX     = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sck,
  input  logic              ssn,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata
);

  logic ssn_s, mosi_s, sck_rise, sck_fall, ssn_fall, ssn_rise;

  spi_slv_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sck_i      (sck),
    .ssn_i      (ssn),
    .mosi_i     (mosi),
    .ssn_o      (ssn_s),
    .mosi_o     (mosi_s),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .ssn_fall_o (ssn_fall),
    .ssn_rise_o (ssn_rise)
  );

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                miso_q, miso_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic                rd_cap_q, rd_cap_d;

  logic                sample_edge, shift_edge;
  logic [DATA_W-1:0]   rx_byte;

  // Modes 0/3 sample on rising sck, modes 1/2 on falling.
  assign sample_edge = (cpol ^ cpha) ? sck_fall : sck_rise;
  assign shift_edge  = (cpol ^ cpha) ? sck_rise : sck_fall;
  assign rx_byte     = {rx_q[DATA_W-2:0], mosi_s};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    // Register file answers one cycle after reg_re; capture then.
    rd_cap_d  = re_q;

`ifdef SPI_SLV_AUTOINC_EN
    // Write address advances only after the strobe has used it.
    if (we_q) begin
      addr_d = addr_q + 7'd1;
    end
`endif

    if (ssn_rise) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
    end else if (ssn_fall) begin
      state_d   = CMD;
      bit_cnt_d = 3'd0;
      if (!cpha) begin
        // cpha=0: the MSB must be on the wire before the first edge.
        miso_d = IDLE_TX[DATA_W-1];
        tx_d   = {IDLE_TX[DATA_W-2:0], 1'b0};
      end else begin
        miso_d = 1'b0;
        tx_d   = IDLE_TX;
      end
    end else if (state_q != IDLE) begin
      // Every byte gets exactly eight presentations before its 8th
      // sample edge, so tx_q is empty and free to reload there.
      if (shift_edge) begin
        miso_d = tx_q[DATA_W-1];
        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
      end
      if (sample_edge) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          tx_d = IDLE_TX;
          unique case (state_q)
            CMD: begin
              addr_d = rx_byte[ADDR_W-1:0];
              if (rx_byte[CMD_RD_BIT]) begin
                state_d = RDATA;
                re_d    = 1'b1;
              end else begin
                state_d = WDATA;
              end
            end
            WDATA: begin
              wdata_d = rx_byte;
              we_d    = 1'b1;
            end
            RDATA: begin
              // Prefetch for the next byte of the burst.
              re_d = 1'b1;
`ifdef SPI_SLV_AUTOINC_EN
              addr_d = addr_q + 7'd1;
`endif
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end
      end
    end

    if (rd_cap_q) begin
      tx_d = reg_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      rd_cap_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      rd_cap_q  <= rd_cap_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = ~ssn_s;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_regif.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : tb_spi_slave_regif                                        |
// | Purpose  : Self-checking bench: SPI master model, register file,     |
// |            frame-level reference model and strobe scoreboard.        |
// |            Honours SPI_SLV_AUTOINC_EN.                               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_spi_slave_regif;

  localparam int         HALF    = 8;      // sck half period in clk cycles (clk/16)
  localparam logic [7:0] IDLE_TX = 8'h00;
`ifdef SPI_SLV_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, sck = 1'b0, ssn = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, reg_we, reg_re;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;

  always #20 clk = ~clk;

  spi_slave_regif #(
    .SYNC_STAGES (2),
    .IDLE_TX     (IDLE_TX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpol      (cpol),
    .cpha      (cpha),
    .sck       (sck),
    .ssn       (ssn),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_we     = 0;
  int n_re     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Register file seen by the DUT (registered read, 1 clk latency).
  logic [7:0] mem [128];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 37 + 11);
    forever begin
      @(posedge clk);
      if (reg_we) mem[reg_addr] = reg_wdata;
      if (reg_re) reg_rdata <= mem[reg_addr];
    end
  end

  // Reference model state and scoreboard queues.
  logic [7:0] mdl_mem [128];
  logic [6:0] exp_wr_a [$];
  logic [7:0] exp_wr_d [$];
  logic [6:0] exp_re_a [$];
  logic [7:0] m_tx   [16];
  logic [7:0] m_rx   [16];
  logic [7:0] exp_rx [16];
  int         n_exp_rx;

  // Frame-level prediction: which strobes the frame must produce and
  // what the master must receive, from nbits clocked by the master.
  task automatic predict(input int nbits);
    int         nb;
    logic       rw;
    logic [6:0] a, ad;
    nb       = nbits / 8;
    n_exp_rx = nb;
    if (nb == 0) return;
    rw        = m_tx[0][7];
    a         = m_tx[0][6:0];
    exp_rx[0] = IDLE_TX;
    if (!rw) begin
      for (int j = 1; j < nb; j++) begin
        ad = AUTOINC ? a + 7'(j - 1) : a;
        exp_wr_a.push_back(ad);
        exp_wr_d.push_back(m_tx[j]);
        mdl_mem[ad] = m_tx[j];
        exp_rx[j]   = IDLE_TX;
      end
    end else begin
      // One read per completed byte: after the command and after each data byte.
      for (int k = 0; k < nb; k++) begin
        ad = AUTOINC ? a + 7'(k) : a;
        exp_re_a.push_back(ad);
        if (k + 1 < nb) exp_rx[k + 1] = mdl_mem[ad];
      end
    end
  endtask

  // Strobe scoreboard, checked every cycle away from the active edge.
  always @(negedge clk) begin
    logic [6:0] ea;
    logic [7:0] ed;
    if (reg_we) begin
      n_we++;
      chk("reg_we expected", 32'(exp_wr_a.size() != 0), 32'd1);
      chk("reg_we/reg_re overlap", 32'(reg_re), 32'd0);
      if (exp_wr_a.size() != 0) begin
        ea = exp_wr_a.pop_front();
        ed = exp_wr_d.pop_front();
        chk("reg_we addr", 32'(reg_addr), 32'(ea));
        chk("reg_we data", 32'(reg_wdata), 32'(ed));
      end
    end
    if (reg_re) begin
      n_re++;
      chk("reg_re expected", 32'(exp_re_a.size() != 0), 32'd1);
      if (exp_re_a.size() != 0) begin
        ea = exp_re_a.pop_front();
        chk("reg_re addr", 32'(reg_addr), 32'(ea));
      end
    end
  end

  // SPI master. rst_bit >= 0 pulses rst_n at that bit and ends the frame.
  task automatic spi_frame(input logic pol, input logic pha, input int nbits, input int rst_bit);
    logic b;
    cpol = pol; cpha = pha; sck = pol; ssn = 1'b1; mosi = 1'b0;
    repeat (4) @(negedge clk);
    ssn = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        rst_n = 1'b0;
        #1;
        chk("rst miso", 32'(miso), 32'd0);
        chk("rst miso_oe", 32'(miso_oe), 32'd0);
        chk("rst reg_we", 32'(reg_we), 32'd0);
        chk("rst reg_re", 32'(reg_re), 32'd0);
        chk("rst reg_addr", 32'(reg_addr), 32'd0);
        chk("rst reg_wdata", 32'(reg_wdata), 32'd0);
        ssn = 1'b1; sck = pol; mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        return;
      end
      b = m_tx[i / 8][7 - (i % 8)];
      if (!pha) begin
        mosi = b;
        repeat (HALF) @(negedge clk);
        sck = ~pol;
        m_rx[i / 8][7 - (i % 8)] = miso;
        repeat (HALF) @(negedge clk);
        sck = pol;
      end else begin
        sck = ~pol;
        mosi = b;
        repeat (HALF) @(negedge clk);
        sck = pol;
        m_rx[i / 8][7 - (i % 8)] = miso;
        repeat (HALF) @(negedge clk);
      end
      if (i == 0) chk("miso_oe in frame", 32'(miso_oe), 32'd1);
    end
    repeat (HALF) @(negedge clk);
    ssn = 1'b1; mosi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic check_frame_end();
    for (int j = 0; j < n_exp_rx; j++) chk("miso byte", 32'(m_rx[j]), 32'(exp_rx[j]));
    chk("write strobes drained", 32'(exp_wr_a.size()), 32'd0);
    chk("read strobes drained", 32'(exp_re_a.size()), 32'd0);
  endtask

  task automatic run_frame(input logic pol, input logic pha, input int nbits);
    predict(nbits);
    spi_frame(pol, pha, nbits, -1);
    check_frame_end();
  endtask

  initial begin
    int we0, re0, nbytes, nbits;
    for (int i = 0; i < 128; i++) mdl_mem[i] = 8'(i * 37 + 11);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset miso", 32'(miso), 32'd0);
    chk("reset miso_oe", 32'(miso_oe), 32'd0);
    chk("reset reg_we", 32'(reg_we), 32'd0);
    chk("reset reg_re", 32'(reg_re), 32'd0);
    chk("reset reg_addr", 32'(reg_addr), 32'd0);
    chk("reset reg_wdata", 32'(reg_wdata), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single write, mode 0
    we0 = n_we;
    m_tx[0] = 8'h05; m_tx[1] = 8'hA7;
    run_frame(1'b0, 1'b0, 16);
    chk("write05 we count", 32'(n_we - we0), 32'd1);
    chk("write05 mem", 32'(mem[5]), 32'hA7);
    chk("write05 reg_wdata", 32'(reg_wdata), 32'hA7);
    chk("write05 miso byte1", 32'(m_rx[1]), 32'h00);

    // Read of 0x3C from address 5 in all four modes
    m_tx[0] = 8'h05; m_tx[1] = 8'h3C;
    run_frame(1'b0, 1'b0, 16);
    for (int md = 0; md < 4; md++) begin
      re0 = n_re;
      m_tx[0] = 8'h85; m_tx[1] = 8'h00;
      run_frame(md[1], md[0], 16);
      chk("read05 data", 32'(m_rx[1]), 32'h3C);
      chk("read05 strobes", 32'(n_re - re0), 32'd2);
    end

    // Write burst at 0x10
    m_tx[0] = 8'h10; m_tx[1] = 8'h11; m_tx[2] = 8'h22; m_tx[3] = 8'h33;
    run_frame(1'b1, 1'b1, 32);
`ifdef SPI_SLV_AUTOINC_EN
    chk("burst mem10", 32'(mem[8'h10]), 32'h11);
    chk("burst mem11", 32'(mem[8'h11]), 32'h22);
    chk("burst mem12", 32'(mem[8'h12]), 32'h33);
    // Address wrap
    m_tx[0] = 8'h7F; m_tx[1] = 8'hAA; m_tx[2] = 8'hBB;
    run_frame(1'b0, 1'b1, 24);
    chk("wrap mem7F", 32'(mem[127]), 32'hAA);
    chk("wrap mem00", 32'(mem[0]), 32'hBB);
`else
    chk("burst mem10", 32'(mem[8'h10]), 32'h33);
`endif

    // Abort after 4 bits of the data byte, then a normal write
    we0 = n_we;
    m_tx[0] = 8'h03; m_tx[1] = 8'hC3;
    run_frame(1'b0, 1'b0, 12);
    chk("abort no we", 32'(n_we - we0), 32'd0);
    m_tx[0] = 8'h02; m_tx[1] = 8'h5A;
    run_frame(1'b0, 1'b0, 16);
    chk("after abort mem02", 32'(mem[2]), 32'h5A);

    // Reset mid read data byte, then a normal frame
    m_tx[0] = 8'h85; m_tx[1] = 8'hFF;
    predict(8);
    re0 = n_re;
    spi_frame(1'b1, 1'b0, 16, 12);
    chk("rst frame cmd byte", 32'(m_rx[0]), 32'(IDLE_TX));
    chk("rst frame strobes", 32'(n_re - re0), 32'd1);
    chk("rst frame drained", 32'(exp_re_a.size()), 32'd0);
    m_tx[0] = 8'h85; m_tx[1] = 8'h00;
    run_frame(1'b1, 1'b0, 16);
    chk("post-reset read", 32'(m_rx[1]), 32'(mdl_mem[5]));

    // Randomised frames
    for (int f = 0; f < 36; f++) begin
      nbytes = int'($urandom_range(1, 5));
      for (int j = 0; j < nbytes + 1; j++) m_tx[j] = 8'($urandom);
      nbits = nbytes * 8;
      if ($urandom_range(0, 5) == 0) nbits = nbits + int'($urandom_range(1, 7));
      run_frame(1'($urandom), 1'($urandom), nbits);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
